// File: rtl/lock.sv
// rtl/lock.sv - four-user password lock with retry counter and latched alarm
module lock #(
  parameter int              PW_W      = 12,
  parameter int              MAX_TRIES = 3,
  parameter logic [PW_W-1:0] DEF_PW0   = 12'h123,
  parameter logic [PW_W-1:0] DEF_PW1   = 12'h456,
  parameter logic [PW_W-1:0] DEF_PW2   = 12'h789,
  parameter logic [PW_W-1:0] DEF_PW3   = 12'h111
) (
  input  logic            Enter,
  input  logic            reset,
  input  logic [PW_W-1:0] PassIn,
  input  logic [1:0]      user,
  output logic            Access,
  output logic [PW_W-1:0] Setpass,
  output logic [1:0]      Count,
  output logic            Alarm
);

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    OPEN   = 2'd1,
    ALARM  = 2'd2
  } state_t;

  // Count is 2 bits, so the trip threshold is taken modulo 4 (legal range 1..3)
  localparam logic [1:0] MAX_CNT = 2'(MAX_TRIES);

  state_t          state, state_nx;
  logic [1:0]      count_q, count_nx;
  logic [1:0]      fail_cnt;
  logic            pw_we;
  logic [PW_W-1:0] pw [4];

  assign fail_cnt = count_q + 2'd1;

  // State register: every Enter edge is one attempt, reset always wins
  always_ff @(posedge Enter or posedge reset) begin
    if (reset) begin
      state <= LOCKED;
    end else begin
      state <= state_nx;
    end
  end

  // Consecutive-failure counter, global across all users
  always_ff @(posedge Enter or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_nx;
    end
  end

  // Password register file; only the addressed slot is written while open
  always_ff @(posedge Enter or posedge reset) begin
    if (reset) begin
      pw[0] <= DEF_PW0;
      pw[1] <= DEF_PW1;
      pw[2] <= DEF_PW2;
      pw[3] <= DEF_PW3;
    end else if (pw_we) begin
      pw[user] <= PassIn;
    end
  end

  // Next-state decision: compare when locked, reprogram when open, freeze in alarm
  always_comb begin
    state_nx = state;
    count_nx = count_q;
    pw_we    = 1'b0;
    case (state)
      LOCKED: begin
        if (PassIn == pw[user]) begin
          state_nx = OPEN;
          count_nx = 2'd0;
        end else begin
          count_nx = fail_cnt;
          if (fail_cnt == MAX_CNT) begin
            state_nx = ALARM;
          end
        end
      end
      OPEN: begin
        pw_we    = 1'b1;
        state_nx = LOCKED;
        count_nx = 2'd0;
      end
      ALARM: begin
        count_nx = MAX_CNT;
      end
      default: begin
        state_nx = LOCKED;
        count_nx = 2'd0;
      end
    endcase
  end

  // Door and alarm drive are decodes of the state flops, so they never overlap
  assign Access  = (state == OPEN);
  assign Alarm   = (state == ALARM);
  assign Count   = count_q;
  assign Setpass = pw[user];

endmodule

// File: tb/tb_lock.sv
// tb/tb_lock.sv - scoreboard bench for the password lock
module tb_lock;

  logic        Enter;
  logic        reset;
  logic [11:0] PassIn;
  logic [1:0]  user;
  logic        Access;
  logic [11:0] Setpass;
  logic [1:0]  Count;
  logic        Alarm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        acc;
    logic [1:0]  cnt;
    logic        alm;
    logic [11:0] sp;
  } exp_t;

  exp_t sbq[$];
  event chk_ev;

  lock dut (
    .Enter   (Enter),
    .reset   (reset),
    .PassIn  (PassIn),
    .user    (user),
    .Access  (Access),
    .Setpass (Setpass),
    .Count   (Count),
    .Alarm   (Alarm)
  );

  task automatic cmp(input string name, input string field, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", name, field, act, exp);
    end
  endtask

  // Monitor: each check strobe pops one expectation and compares DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow got=empty want=entry");
      end else begin
        e = sbq.pop_front();
        cmp(e.name, "Access",  {11'd0, Access}, {11'd0, e.acc});
        cmp(e.name, "Count",   {10'd0, Count},  {10'd0, e.cnt});
        cmp(e.name, "Alarm",   {11'd0, Alarm},  {11'd0, e.alm});
        cmp(e.name, "Setpass", Setpass,         e.sp);
        cmp(e.name, "excl",    {11'd0, Access & Alarm}, 12'd0);
      end
    end
  end

  task automatic expect_out(input string name, input logic acc, input logic [1:0] cnt,
                            input logic alm, input logic [11:0] sp);
    exp_t e;
    e.name = name;
    e.acc  = acc;
    e.cnt  = cnt;
    e.alm  = alm;
    e.sp   = sp;
    sbq.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #7;
    reset = 1'b0;
    #3;
  endtask

  task automatic attempt(input logic [1:0] u, input logic [11:0] code);
    user   = u;
    PassIn = code;
    #2;
    Enter = 1'b1;
    #5;
    Enter = 1'b0;
    #5;
  endtask

  initial begin
    Enter  = 1'b0;
    reset  = 1'b0;
    PassIn = 12'h000;
    user   = 2'd3;
    #3;

    // 1: reset state and combinational readout
    do_reset();
    expect_out("rst_u3", 1'b0, 2'd0, 1'b0, 12'h111);
    user = 2'd0;
    #1;
    expect_out("rst_u0", 1'b0, 2'd0, 1'b0, 12'h123);

    // 2: open as user 3, then reprogram
    do_reset();
    attempt(2'd3, 12'h111);
    expect_out("open_u3", 1'b1, 2'd0, 1'b0, 12'h111);
    attempt(2'd3, 12'h0AA);
    expect_out("write_u3", 1'b0, 2'd0, 1'b0, 12'h0AA);
    user = 2'd0; #1;
    expect_out("keep_u0", 1'b0, 2'd0, 1'b0, 12'h123);
    user = 2'd1; #1;
    expect_out("keep_u1", 1'b0, 2'd0, 1'b0, 12'h456);
    user = 2'd2; #1;
    expect_out("keep_u2", 1'b0, 2'd0, 1'b0, 12'h789);

    // 3: three failures trip the alarm; further entries are ignored
    attempt(2'd3, 12'hF1A);
    expect_out("fail1", 1'b0, 2'd1, 1'b0, 12'h0AA);
    attempt(2'd3, 12'h999);
    expect_out("fail2", 1'b0, 2'd2, 1'b0, 12'h0AA);
    attempt(2'd3, 12'h001);
    expect_out("fail3_alarm", 1'b0, 2'd3, 1'b1, 12'h0AA);
    attempt(2'd3, 12'h0AA);
    expect_out("alarm_hold", 1'b0, 2'd3, 1'b1, 12'h0AA);
    attempt(2'd3, 12'h111);
    expect_out("alarm_nowrite", 1'b0, 2'd3, 1'b1, 12'h0AA);

    // 4: reset coincident with an Enter edge while in alarm
    user   = 2'd3;
    PassIn = 12'h188;
    #2;
    reset = 1'b1;
    Enter = 1'b1;
    #10;
    reset = 1'b0;
    Enter = 1'b0;
    #5;
    expect_out("rst_in_alarm", 1'b0, 2'd0, 1'b0, 12'h111);
    attempt(2'd3, 12'h111);
    expect_out("reopen_u3", 1'b1, 2'd0, 1'b0, 12'h111);

    // 6: reset while open clears Access without an Enter edge
    reset = 1'b1;
    #1;
    expect_out("rst_in_open", 1'b0, 2'd0, 1'b0, 12'h111);
    #4;
    reset = 1'b0;
    #3;

    // 5: failure count is shared across users and cleared by any success
    do_reset();
    attempt(2'd0, 12'h000);
    expect_out("g_fail1", 1'b0, 2'd1, 1'b0, 12'h123);
    attempt(2'd0, 12'h000);
    expect_out("g_fail2", 1'b0, 2'd2, 1'b0, 12'h123);
    attempt(2'd1, 12'h456);
    expect_out("g_open_u1", 1'b1, 2'd0, 1'b0, 12'h456);
    PassIn = 12'hABC;
    user   = 2'd1;
    #4;
    expect_out("open_idle", 1'b1, 2'd0, 1'b0, 12'h456);
    attempt(2'd1, 12'h456);
    expect_out("write_same", 1'b0, 2'd0, 1'b0, 12'h456);
    attempt(2'd2, 12'h000);
    expect_out("u2_fail1", 1'b0, 2'd1, 1'b0, 12'h789);
    attempt(2'd2, 12'h789);
    expect_out("u2_open", 1'b1, 2'd0, 1'b0, 12'h789);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 100 && sbq.size() != 0; i++) #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock.md
Name: lock

Overview:
- Four-user password lock controller with per-user 12-bit passwords.
- Each rising edge of Enter is one entry attempt: the value on PassIn is checked against the stored password of the user selected by `user`.
- A correct entry grants Access. While open, the next entry stores a new password and relocks.
- After MAX_TRIES consecutive wrong entries the block latches Alarm until reset. It sits between a keypad/user-select front end and the door actuator/alarm driver.

Parameters:
- PW_W, 12, password width in bits.
- MAX_TRIES, 3, consecutive failures that trigger the alarm; legal range 1..3 (Count is 2 bits).
- DEF_PW0, 12'h123, password of user 0 after reset.
- DEF_PW1, 12'h456, password of user 1 after reset.
- DEF_PW2, 12'h789, password of user 2 after reset.
- DEF_PW3, 12'h111, password of user 3 after reset.

Ports:
- Enter  input  1  clock. Single clock; every rising edge is one entry attempt.
- reset  input  1  asynchronous, active-high reset.
- PassIn  input  PW_W  entered code; sampled on the Enter rising edge.
- user  input  2  user select (0..3); sampled on the Enter rising edge. Also addresses the Setpass readout.
- Access  output  1  1 while the lock is open.
- Setpass  output  PW_W  stored password of the currently selected user. Combinational; follows `user` immediately.
- Count  output  2  consecutive failed attempts; saturates at MAX_TRIES.
- Alarm  output  1  latched alarm.

Behaviour:
- Reset (asynchronous, reset=1):
  - state=LOCKED, Access=0, Count=0, Alarm=0.
  - pw[0..3] = DEF_PW0..DEF_PW3.
  - Enter edges are ignored while reset is high.
- All other state changes occur only on the Enter rising edge. There is no other clock.
- State LOCKED, on an Enter edge:
  - PassIn==pw[user]: go to OPEN, Access=1, Count=0.
  - Mismatch: Count=Count+1. If the new Count==MAX_TRIES, go to ALARM and set Alarm=1; otherwise stay in LOCKED.
- State OPEN, on an Enter edge:
  - Load pw[user]=PassIn, whatever its value (a value equal to the old password is allowed).
  - Go to LOCKED, Access=0, Count=0.
  - Only the addressed user slot is written; the other three are unchanged.
- State ALARM:
  - All Enter edges are ignored: no compare, no write.
  - Count holds MAX_TRIES, Alarm=1, Access=0.
  - The only exit is reset.
- Output timing: Access, Count and Alarm are registered and update on the same Enter edge as the decision (zero-edge latency after the attempt edge).
- Invariants:
  - Access and Alarm are never both 1.
  - Count==0 whenever Access=1.
- Count never wraps: its maximum value is MAX_TRIES.
- Failure counting is global across users, not per user. A successful entry by any user clears it.
- Setpass changes combinationally with `user`. After a password write, Setpass reflects the new value immediately after that Enter edge.
- Reset asserted mid-sequence, including in OPEN or ALARM, or coincident with an Enter edge: reset wins and the Enter edge is dropped.
- PassIn/user changes between Enter edges have no effect except on the Setpass readout.
- Encoding: 3-state FSM (LOCKED, OPEN, ALARM), 4×PW_W password register file, 2-bit counter.

Test Plan:
1. Reset then idle, user=3 -> Access=0, Alarm=0, Count=0, Setpass=12'h111. Switching to user=0 gives Setpass=12'h123.
2. Reset, user=3, then Enter with PassIn=12'h111 -> Access=1, Count=0. Next Enter with PassIn=12'h0AA -> Access=0, Setpass=12'h0AA, other users' passwords unchanged.
3. Continuing from scenario 2: Enter with 12'hF1A, then 12'h999, then 12'h001 -> Count steps 1, 2, 3, and Alarm=1 after the third edge. A further Enter with 12'h0AA changes nothing (Access=0, Count=3).
4. Assert reset in ALARM while Enter is high with PassIn=12'h188, release after 10 time units -> Alarm=0, Count=0, Setpass=12'h111 (default restored). A following Enter with 12'h111 -> Access=1.
5. Global counter: from reset, user=0 enters 12'h000 twice (Count=2), then user=1 enters 12'h456 -> Access=1, Count=0.
6. Reset asserted while in OPEN -> Access drops to 0 immediately, without waiting for an Enter edge.
